// File: rtl/comp_scan_ctrl_pkg.sv
// Shared types and helpers for the comparator scan controller.
// Optional hysteresis is enabled by defining COMP_SCAN_HYST_EN.
package comp_scan_ctrl_pkg;

    localparam int unsigned W_DEF = 5;
    localparam int unsigned ST_W  = 3;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_CMP  = 3'd2,
        ST_UPD  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Ceiling log2 with a floor of 1 so a 1-bit index is always available.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/comp_scan_ctrl_cmp.sv
// Shared unsigned magnitude comparator: ge_c = 1 when a >= b.
module comp_scan_ctrl_cmp
    import comp_scan_ctrl_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ge_c
);

    assign ge_c = (a >= b);

endmodule

// File: rtl/comp_scan_ctrl.sv
// Round-robin scan controller sharing one comparator across N_CH debounced alarms.
// Define COMP_SCAN_HYST_EN to lower the clear threshold by HYST while an alarm is set.
module comp_scan_ctrl
    import comp_scan_ctrl_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = W_DEF,
    parameter int unsigned DEB  = 3,
    parameter int unsigned HYST = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [N_CH-1:0]            ch_en,
    input  logic [N_CH*W-1:0]          sample_bus,
    input  logic [N_CH*W-1:0]          thresh_bus,
    output logic                       busy,
    output logic                       done,
    output logic [N_CH-1:0]            alarm,
    output logic [clog2(N_CH)-1:0]     cur_ch
);

    localparam int unsigned CH_W = clog2(N_CH);

`ifdef COMP_SCAN_HYST_EN
    localparam bit HYST_EN = 1'b1;
`else
    localparam bit HYST_EN = 1'b0;
`endif

    // Effective clear margin; zero makes the set and clear thresholds identical.
    localparam logic [W-1:0] HYST_M = HYST_EN ? W'(HYST) : '0;

    state_e               state_q, state_d;
    logic [CH_W-1:0]      cur_ch_q, cur_ch_d;
    logic [W-1:0]         a_q, a_d;
    logic [W-1:0]         b_q, b_d;
    logic                 cmp_q, cmp_d;
    logic [N_CH-1:0]      alarm_q, alarm_d;
    logic [CNT_W-1:0]     cnt_q [N_CH];
    logic [CNT_W-1:0]     cnt_d [N_CH];
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [W-1:0]         samp_c [N_CH];
    logic [W-1:0]         thr_c  [N_CH];
    logic [W-1:0]         thr_sel_c;
    logic [W-1:0]         thr_clr_c;
    logic                 last_c;
    logic                 ge_c;

    comp_scan_ctrl_cmp #(
        .W (W)
    ) u_cmp (
        .a    (a_q),
        .b    (b_q),
        .ge_c (ge_c)
    );

    always_comb begin
        for (int i = 0; i < int'(N_CH); i++) begin
            samp_c[i] = sample_bus[i*W +: W];
            thr_c[i]  = thresh_bus[i*W +: W];
        end
    end

    // Clear threshold saturates at zero so a small threshold cannot wrap.
    always_comb begin
        thr_sel_c = thr_c[cur_ch_q];
        thr_clr_c = (thr_sel_c >= HYST_M) ? W'(thr_sel_c - HYST_M) : '0;
        last_c    = (cur_ch_q == CH_W'(N_CH - 1));
    end

    // Next-state, datapath and debounce update.
    always_comb begin
        state_d  = state_q;
        cur_ch_d = cur_ch_q;
        a_d      = a_q;
        b_d      = b_q;
        cmp_d    = cmp_q;
        alarm_d  = alarm_q;
        for (int i = 0; i < int'(N_CH); i++) begin
            cnt_d[i] = cnt_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_ch_d = '0;
                    state_d  = ST_SEL;
                end
            end
            ST_SEL: begin
                if (ch_en[cur_ch_q]) begin
                    a_d     = samp_c[cur_ch_q];
                    b_d     = alarm_q[cur_ch_q] ? thr_clr_c : thr_sel_c;
                    state_d = ST_CMP;
                end else begin
                    alarm_d[cur_ch_q] = 1'b0;
                    cnt_d[cur_ch_q]   = '0;
                    if (last_c) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_ch_d = CH_W'(cur_ch_q + 1'b1);
                        state_d  = ST_SEL;
                    end
                end
            end
            ST_CMP: begin
                cmp_d   = ge_c;
                state_d = ST_UPD;
            end
            ST_UPD: begin
                if (cmp_q == alarm_q[cur_ch_q]) begin
                    cnt_d[cur_ch_q] = '0;
                end else if (cnt_q[cur_ch_q] == CNT_W'(DEB - 1)) begin
                    alarm_d[cur_ch_q] = cmp_q;
                    cnt_d[cur_ch_q]   = '0;
                end else begin
                    cnt_d[cur_ch_q] = CNT_W'(cnt_q[cur_ch_q] + 1'b1);
                end
                if (last_c) begin
                    state_d = ST_DONE;
                end else begin
                    cur_ch_d = CH_W'(cur_ch_q + 1'b1);
                    state_d  = ST_SEL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cur_ch_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cmp_q    <= 1'b0;
            alarm_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cur_ch_q <= cur_ch_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cmp_q    <= cmp_d;
            alarm_q  <= alarm_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign alarm  = alarm_q;
    assign cur_ch = cur_ch_q;

endmodule
